// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit for the execute stage.
//
// Ports:
//   clk      - clock, all state updates on the rising edge
//   reset    - synchronous active-high reset
//   start    - operation request, only sampled while idle
//   kill     - pipeline flush, aborts any in-flight operation
//   funct3   - M-extension op select (MUL..REMU)
//   srcA     - rs1 operand
//   srcB     - rs2 operand
//   rd_in    - destination register tag accompanying the request
//   busy     - operation in flight, new requests are not accepted
//   done     - one-cycle pulse, result/rd_out valid
//   result   - result value, held until the next done
//   rd_out   - tag of result, held with result
//
// Latency: MUL family and the divide fast paths (divide by zero, signed
// overflow) pulse done two cycles after start; a real divide takes XLEN
// iterations plus a sign-fix cycle and pulses done at cycle XLEN+2.
module muldiv_unit #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned TAGW = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            kill,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] srcA,
    input  logic [XLEN-1:0] srcB,
    input  logic [TAGW-1:0] rd_in,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [TAGW-1:0] rd_out
);

    localparam int unsigned CW = $clog2(XLEN + 1);
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV,
        FIX
    } stateT;

    stateT           state;
    logic [1:0]      opReg;      // funct3[1:0] of the accepted op
    logic [XLEN-1:0] aReg;       // raw operands
    logic [XLEN-1:0] bReg;
    logic [XLEN-1:0] divisor;    // divisor magnitude
    logic [XLEN-1:0] quoReg;     // dividend magnitude shifting out, quotient shifting in
    logic [XLEN-1:0] remReg;     // partial remainder
    logic            negQ;
    logic            negR;
    logic            divZero;
    logic            divOvf;
    logic [TAGW-1:0] rdReg;
    logic [CW-1:0]   cnt;

    // Request-side decode, evaluated on the live inputs while idle.
    logic            divSigned;
    logic [XLEN-1:0] magA;
    logic [XLEN-1:0] magB;

    always_comb begin
        divSigned = ~funct3[0];
        magA      = (divSigned && srcA[XLEN-1]) ? ('0 - srcA) : srcA;
        magB      = (divSigned && srcB[XLEN-1]) ? ('0 - srcB) : srcB;
    end

    // Multiplier: operands sign- or zero-extended to 2*XLEN, so the low
    // 2*XLEN product bits equal those of the (XLEN+1)-bit signed product.
    logic              aSigned;
    logic              bSigned;
    logic [2*XLEN-1:0] aWide;
    logic [2*XLEN-1:0] bWide;
    logic [2*XLEN-1:0] product;
    logic [XLEN-1:0]   mulResult;

    always_comb begin
        aSigned   = (opReg == 2'b01) || (opReg == 2'b10);
        bSigned   = (opReg == 2'b01);
        aWide     = {{XLEN{aSigned & aReg[XLEN-1]}}, aReg};
        bWide     = {{XLEN{bSigned & bReg[XLEN-1]}}, bReg};
        product   = aWide * bWide;
        mulResult = (opReg == 2'b00) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];
    end

    // One restoring divide step: shift in the next dividend bit, try to
    // subtract the divisor, keep the difference only if it did not borrow.
    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;
    logic          qBit;

    always_comb begin
        shifted = {remReg, quoReg[XLEN-1]};
        diff    = shifted - {1'b0, divisor};
        qBit    = ~diff[XLEN];
    end

    // Final result selection with sign correction and special cases.
    logic [XLEN-1:0] fixResult;

    always_comb begin
        fixResult = '0;
        if (divZero) begin
            fixResult = opReg[1] ? aReg : '1;
        end else if (divOvf) begin
            fixResult = opReg[1] ? '0 : INT_MIN;
        end else if (opReg[1]) begin
            fixResult = negR ? ('0 - remReg) : remReg;
        end else begin
            fixResult = negQ ? ('0 - quoReg) : quoReg;
        end
    end

    always_ff @(posedge clk) begin
        done <= 1'b0;
        if (reset) begin
            state   <= IDLE;
            busy    <= 1'b0;
            result  <= '0;
            rd_out  <= '0;
            cnt     <= '0;
            opReg   <= '0;
            aReg    <= '0;
            bReg    <= '0;
            divisor <= '0;
            quoReg  <= '0;
            remReg  <= '0;
            negQ    <= 1'b0;
            negR    <= 1'b0;
            divZero <= 1'b0;
            divOvf  <= 1'b0;
            rdReg   <= '0;
        end else if (kill) begin
            // Abort: drop back to idle without touching result/rd_out.
            state <= IDLE;
            busy  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        busy    <= 1'b1;
                        opReg   <= funct3[1:0];
                        aReg    <= srcA;
                        bReg    <= srcB;
                        rdReg   <= rd_in;
                        negQ    <= divSigned & (srcA[XLEN-1] ^ srcB[XLEN-1]);
                        negR    <= divSigned & srcA[XLEN-1];
                        divZero <= 1'b0;
                        divOvf  <= 1'b0;
                        if (!funct3[2]) begin
                            state <= MUL;
                        end else if (srcB == '0) begin
                            divZero <= 1'b1;
                            state   <= FIX;
                        end else if (divSigned && srcA == INT_MIN && srcB == '1) begin
                            divOvf <= 1'b1;
                            state  <= FIX;
                        end else begin
                            quoReg  <= magA;
                            remReg  <= '0;
                            divisor <= magB;
                            cnt     <= '0;
                            state   <= DIV;
                        end
                    end
                end
                MUL: begin
                    // Multiply needs no sign fix, so the product is selected
                    // and published straight from this state, giving done in
                    // the same cycle a fast-path divide reaches it.
                    result <= mulResult;
                    rd_out <= rdReg;
                    done   <= 1'b1;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                DIV: begin
                    remReg <= qBit ? diff[XLEN-1:0] : shifted[XLEN-1:0];
                    quoReg <= {quoReg[XLEN-2:0], qBit};
                    cnt    <= cnt + 1'b1;
                    if (cnt == CW'(XLEN - 1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    result <= fixResult;
                    rd_out <= rdReg;
                    done   <= 1'b1;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Testbench for muldiv_unit: randomized and directed RV32M ops checked by a
// queue-based scoreboard against an arithmetic reference model.
module tb_muldiv_unit;

    localparam int unsigned XLEN = 32;
    localparam int unsigned TAGW = 5;

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic            kill;
    logic [2:0]      funct3;
    logic [XLEN-1:0] srcA;
    logic [XLEN-1:0] srcB;
    logic [TAGW-1:0] rd_in;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;
    logic [TAGW-1:0] rd_out;

    muldiv_unit #(.XLEN(XLEN), .TAGW(TAGW)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .kill   (kill),
        .funct3 (funct3),
        .srcA   (srcA),
        .srcB   (srcB),
        .rd_in  (rd_in),
        .busy   (busy),
        .done   (done),
        .result (result),
        .rd_out (rd_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int passes = 0;

    typedef struct {
        logic [XLEN-1:0] res;
        logic [TAGW-1:0] rd;
        int              due;
    } expT;

    expT             sb[$];
    bit              checking = 1'b0;
    int              busyFrom = 1;
    int              busyTo   = 0;
    logic [XLEN-1:0] heldRes  = '0;
    logic [TAGW-1:0] heldRd   = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference model straight from the RV32M definitions.
    function automatic logic [XLEN-1:0] model(input logic [2:0] f, input logic [XLEN-1:0] a,
                                              input logic [XLEN-1:0] b);
        longint      sa;
        longint      sb2;
        longint      ub;
        logic [63:0] p;
        sa  = longint'($signed(a));
        sb2 = longint'($signed(b));
        ub  = {32'd0, b};
        case (f)
            3'd0: begin p = sa * sb2; return p[31:0]; end
            3'd1: begin p = sa * sb2; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFFFFFF;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
                p = sa / sb2; return p[31:0];
            end
            3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
                p = sa % sb2; return p[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Cycle of done relative to the start cycle.
    function automatic int latOf(input logic [2:0] f, input logic [XLEN-1:0] a,
                                 input logic [XLEN-1:0] b);
        if (!f[2]) return 2;
        if (b == 0) return 2;
        if (!f[0] && a == 32'h80000000 && b == 32'hFFFFFFFF) return 2;
        return 34;
    endfunction

    function automatic logic [XLEN-1:0] rndOp();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFFFFFF;
            2: return 32'h80000000;
            3: return 32'($urandom_range(0, 15));
            default: return 32'($urandom);
        endcase
    endfunction

    // Called at posedge+#1 of cycle 0; returns at posedge+#1 of cycle 1.
    task automatic launchExp(input logic [2:0] f, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                             input logic [TAGW-1:0] rd, input logic [XLEN-1:0] expRes, input bit doPush);
        int lat;
        lat    = latOf(f, a, b);
        start  = 1'b1;
        funct3 = f;
        srcA   = a;
        srcB   = b;
        rd_in  = rd;
        if (doPush) sb.push_back('{res: expRes, rd: rd, due: cyc + lat});
        busyFrom = cyc + 1;
        busyTo   = cyc + lat - 1;
        @(posedge clk); #1;
        start  = 1'b0;
        funct3 = 3'($urandom);
        srcA   = $urandom;
        srcB   = $urandom;
        rd_in  = 5'($urandom);
    endtask

    task automatic launch(input logic [2:0] f, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                          input logic [TAGW-1:0] rd, input bit doPush);
        launchExp(f, a, b, rd, model(f, a, b), doPush);
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && sb.size() != 0; i++) begin
            @(posedge clk); #1;
        end
        chk("drain_pending", 64'(sb.size()), 64'd0);
        sb.delete();
    endtask

    task automatic idleCycles(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    // Monitor: busy window, done pulses against the scoreboard, held outputs.
    always @(negedge clk) begin : monitor
        expT t;
        if (checking) begin
            chk("busy", 64'(busy), 64'((cyc >= busyFrom) && (cyc <= busyTo)));
            if (done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 64'(done), 64'd0);
                end else begin
                    t = sb.pop_front();
                    chk("result", 64'(result), 64'(t.res));
                    chk("rd_out", 64'(rd_out), 64'(t.rd));
                    chk("done_cycle", 64'(cyc), 64'(t.due));
                    heldRes = t.res;
                    heldRd  = t.rd;
                end
            end else begin
                chk("result_held", 64'(result), 64'(heldRes));
                chk("rd_held", 64'(rd_out), 64'(heldRd));
            end
        end
    end

    initial begin
        if (cyc > 40000) ;
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [2:0]      f;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [TAGW-1:0] rd;
        logic [XLEN-1:0] exp;
    } dirT;

    dirT dirTab[$] = '{
        '{3'd0, 32'd7,          32'hFFFFFFFD, 5'd1,  32'hFFFFFFEB},
        '{3'd3, 32'hFFFFFFFF,   32'hFFFFFFFF, 5'd2,  32'hFFFFFFFE},
        '{3'd2, 32'hFFFFFFFF,   32'hFFFFFFFF, 5'd3,  32'hFFFFFFFF},
        '{3'd1, 32'hFFFFFFFF,   32'hFFFFFFFF, 5'd4,  32'h00000000},
        '{3'd4, 32'hFFFFFFF9,   32'd2,        5'd5,  32'hFFFFFFFD},
        '{3'd6, 32'hFFFFFFF9,   32'd2,        5'd5,  32'hFFFFFFFF},
        '{3'd5, 32'd100,        32'd7,        5'd5,  32'd14},
        '{3'd7, 32'd100,        32'd7,        5'd5,  32'd2},
        '{3'd5, 32'd1234,       32'd0,        5'd6,  32'hFFFFFFFF},
        '{3'd6, 32'd1234,       32'd0,        5'd7,  32'd1234},
        '{3'd4, 32'h80000000,   32'hFFFFFFFF, 5'd8,  32'h80000000},
        '{3'd6, 32'h80000000,   32'hFFFFFFFF, 5'd9,  32'h00000000}
    };

    initial begin
        reset  = 1'b1;
        start  = 1'b0;
        kill   = 1'b0;
        funct3 = '0;
        srcA   = '0;
        srcB   = '0;
        rd_in  = '0;
        idleCycles(3);
        reset    = 1'b0;
        checking = 1'b1;
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_result", 64'(result), 64'd0);
        chk("reset_rd", 64'(rd_out), 64'd0);

        // Directed cases with hand-derived results.
        foreach (dirTab[i]) begin
            launchExp(dirTab[i].f, dirTab[i].a, dirTab[i].b, dirTab[i].rd, dirTab[i].exp, 1'b1);
            drain(60);
        end

        // Kill mid-divide at cycle 10, then a quick MUL.
        launch(3'd4, 32'd1000, 32'd3, 5'd10, 1'b0);
        idleCycles(9);
        kill   = 1'b1;
        busyTo = cyc;
        idleCycles(1);
        kill = 1'b0;
        idleCycles(40);
        launchExp(3'd0, 32'd3, 32'd4, 5'd11, 32'd12, 1'b1);
        drain(10);

        // Kill in the FIX cycle of a fast path, and in the MUL cycle.
        launch(3'd5, 32'd5, 32'd0, 5'd12, 1'b0);
        kill   = 1'b1;
        busyTo = cyc;
        idleCycles(1);
        kill = 1'b0;
        idleCycles(3);
        launch(3'd0, 32'd9, 32'd9, 5'd13, 1'b0);
        kill   = 1'b1;
        busyTo = cyc;
        idleCycles(1);
        kill = 1'b0;
        idleCycles(3);

        // kill together with start while idle: request dropped.
        start = 1'b1; kill = 1'b1; funct3 = 3'd0; srcA = 32'd2; srcB = 32'd2;
        idleCycles(1);
        start = 1'b0; kill = 1'b0;
        idleCycles(4);

        // start re-asserted during cycles 5..20 of a divide is ignored.
        launch(3'd4, 32'hFFFF0001, 32'd77, 5'd14, 1'b1);
        idleCycles(4);
        for (int i = 0; i < 16; i++) begin
            start  = 1'b1;
            funct3 = 3'($urandom);
            srcA   = $urandom;
            srcB   = $urandom;
            rd_in  = 5'($urandom);
            idleCycles(1);
        end
        start = 1'b0;
        drain(60);

        // Back-to-back: each start issued in the done cycle of the previous op.
        for (int i = 0; i < 8; i++) begin
            logic [2:0]      f;
            logic [XLEN-1:0] a;
            logic [XLEN-1:0] b;
            f = 3'($urandom);
            a = rndOp();
            b = rndOp();
            launch(f, a, b, 5'($urandom), 1'b1);
            idleCycles(latOf(f, a, b) - 1);
        end
        drain(60);

        // Randomized ops.
        for (int i = 0; i < 40; i++) begin
            launch(3'($urandom), rndOp(), rndOp(), 5'($urandom), 1'b1);
            drain(60);
        end

        // Reset at cycle 15 of a divide: outputs clear, no done.
        launch(3'd7, 32'd123456, 32'd789, 5'd15, 1'b1);
        idleCycles(14);
        reset  = 1'b1;
        busyTo = cyc;
        idleCycles(1);
        reset   = 1'b0;
        sb.delete();
        heldRes = '0;
        heldRd  = '0;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_result", 64'(result), 64'd0);
        chk("rst_rd", 64'(rd_out), 64'd0);
        idleCycles(40);

        checking = 1'b0;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
